// File: rtl/sequencer_pkg.sv
// Shared opcode, state, path-index and error-code definitions for the path sequencer.
package sequencer_pkg;

  localparam logic [6:0] OpcR   = 7'b0110011;
  localparam logic [6:0] OpcIOp = 7'b0010011;
  localparam logic [6:0] OpcILd = 7'b0000011;
  localparam logic [6:0] OpcU   = 7'b0110111;
  localparam logic [6:0] OpcB   = 7'b1100011;
  localparam logic [6:0] OpcJ   = 7'b1101111;
  localparam logic [6:0] OpcS   = 7'b0100011;
  localparam logic [6:0] OpcNop = 7'b0000000;

  typedef enum logic [2:0] {
    StIdle,
    StDispatch,
    StRelease,
    StMerge,
    StDrain,
    StAck
  } state_e;

  localparam logic [1:0] PathBranch = 2'd0;
  localparam logic [1:0] PathStore  = 2'd1;
  localparam logic [1:0] PathAlu    = 2'd2;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrIllegal = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  function automatic logic [2:0] path_onehot(logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  function automatic logic [1:0] path_idx(logic [2:0] onehot);
    if (onehot[2]) return PathAlu;
    if (onehot[1]) return PathStore;
    return PathBranch;
  endfunction

endpackage

// File: rtl/opcode_class_dec.sv
// Combinational opcode classifier: one-hot execution path plus an illegal flag.
module opcode_class_dec
  import sequencer_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] path_o,
  output logic       illegal_o
);

  always_comb begin
    path_o    = 3'b000;
    illegal_o = 1'b0;
    case (opcode_i)
      OpcB, OpcJ:                   path_o = path_onehot(PathBranch);
      OpcS:                         path_o = path_onehot(PathStore);
      OpcR, OpcIOp, OpcILd, OpcNop: path_o = path_onehot(PathAlu);
      default:                      illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/path_sequencer.sv
// Sequences one instruction through a single execution path and merges its completion
// downstream, with illegal-opcode reporting, a per-phase watchdog and a retire counter.
module path_sequencer
  import sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_req,
  input  logic [6:0]       in_opcode,
  output logic             in_ack,
  output logic [1:0]       in_err,
  output logic [2:0]       path_req,
  input  logic [2:0]       path_ack,
  output logic             out_req,
  output logic [1:0]       out_sel,
  input  logic             out_ack,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [2:0]       cls_q, cls_d;
  logic [1:0]       err_q, err_d;
  logic [WdW-1:0]   wdog_q, wdog_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             armed_q, armed_d;

  logic             in_ack_q, in_ack_d;
  logic [1:0]       in_err_q, in_err_d;
  logic [2:0]       path_req_q, path_req_d;
  logic             out_req_q, out_req_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic             busy_q, busy_d;

  logic [2:0]       dec_path;
  logic             dec_illegal;
  logic             sel_ack;
  logic             wd_expired;

  opcode_class_dec u_dec (
    .opcode_i (in_opcode),
    .path_o   (dec_path),
    .illegal_o(dec_illegal)
  );

  assign sel_ack    = |(path_ack & cls_q);
  assign wd_expired = (wdog_q == WdLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cls_q      <= 3'b000;
      err_q      <= ErrOk;
      wdog_q     <= '0;
      retired_q  <= '0;
      armed_q    <= 1'b0;
      in_ack_q   <= 1'b0;
      in_err_q   <= ErrOk;
      path_req_q <= 3'b000;
      out_req_q  <= 1'b0;
      out_sel_q  <= PathBranch;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
      retired_q  <= retired_d;
      armed_q    <= armed_d;
      in_ack_q   <= in_ack_d;
      in_err_q   <= in_err_d;
      path_req_q <= path_req_d;
      out_req_q  <= out_req_d;
      out_sel_q  <= out_sel_d;
      busy_q     <= busy_d;
    end
  end

  // armed_q demands in_req be seen low before a new request is accepted.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    err_d     = err_q;
    retired_d = retired_q;
    armed_d   = armed_q | ~in_req;
    case (state_q)
      StIdle: begin
        if (in_req && armed_q) begin
          armed_d = 1'b0;
          cls_d   = dec_path;
          if (dec_illegal) begin
            err_d   = ErrIllegal;
            state_d = StAck;
          end else begin
            err_d   = ErrOk;
            state_d = StDispatch;
          end
        end
      end
      StDispatch: begin
        if (sel_ack) begin
          state_d = StRelease;
        end else if (wd_expired) begin
          err_d   = ErrTimeout;
          state_d = StAck;
        end
      end
      StRelease: begin
        if (!sel_ack) begin
          state_d = StMerge;
        end else if (wd_expired) begin
          err_d   = ErrTimeout;
          state_d = StAck;
        end
      end
      StMerge: if (out_ack) state_d = StDrain;
      StDrain: if (!out_ack) state_d = StAck;
      StAck: begin
        if (!in_req) begin
          state_d = StIdle;
          if (err_q == ErrOk) retired_d = retired_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Watchdog restarts on each state change and only advances while waiting on a path.
  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (state_q == StDispatch || state_q == StRelease) begin
      wdog_d = wdog_q + WdW'(1);
    end
  end

  // Outputs are decoded from the next state so they leave the flops aligned with it.
  always_comb begin
    path_req_d = 3'b000;
    out_req_d  = 1'b0;
    out_sel_d  = PathBranch;
    in_ack_d   = 1'b0;
    in_err_d   = ErrOk;
    busy_d     = (state_d != StIdle);
    case (state_d)
      StDispatch: path_req_d = cls_d;
      StMerge: begin
        out_req_d = 1'b1;
        out_sel_d = path_idx(cls_d);
      end
      StAck: begin
        in_ack_d = 1'b1;
        in_err_d = err_d;
      end
      default: ;
    endcase
  end

  assign in_ack   = in_ack_q;
  assign in_err   = in_err_q;
  assign path_req = path_req_q;
  assign out_req  = out_req_q;
  assign out_sel  = out_sel_q;
  assign busy     = busy_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_path_sequencer.sv
// Directed bench for path_sequencer: per-cycle trace model plus literal spot checks.
module tb_path_sequencer;

  localparam int TO = 4;
  localparam int H  = 8;
  localparam int G  = 2;

  localparam int PhIdle = 0;
  localparam int PhDisp = 1;
  localparam int PhRel  = 2;
  localparam int PhMrg  = 3;
  localparam int PhDrn  = 4;
  localparam int PhAck  = 5;

  typedef struct packed {
    logic [2:0] preq;
    logic       oreq;
    logic [1:0] osel;
    logic       iack;
    logic [1:0] ierr;
    logic       busy;
    logic [3:0] ret;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_req;
  logic [6:0] in_opcode;
  logic       in_ack;
  logic [1:0] in_err;
  logic [2:0] path_req;
  logic [2:0] path_ack;
  logic       out_req;
  logic [1:0] out_sel;
  logic       out_ack;
  logic       busy;
  logic [3:0] retired;

  logic       echo_en;
  logic [2:0] noise;

  int vectors = 0;
  int miscompares = 0;

  snap_t      exp_q[$];
  logic [3:0] ret_m;

  // Monitor state
  logic       prev_req, prev_ack, prev_oreq;
  int         lat_cnt, last_lat, preq_cyc;
  logic [2:0] last_preq;
  logic [1:0] last_err;
  logic       preq_any, oreq_any, overlap;
  logic [1:0] sel_log[$];

  path_sequencer #(
    .TIMEOUT(TO),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_req   (in_req),
    .in_opcode(in_opcode),
    .in_ack   (in_ack),
    .in_err   (in_err),
    .path_req (path_req),
    .path_ack (path_ack),
    .out_req  (out_req),
    .out_sel  (out_sel),
    .out_ack  (out_ack),
    .busy     (busy),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  // Zero-latency responders; noise drives extra path_ack bits.
  assign path_ack = (echo_en ? path_req : 3'b000) | noise;
  assign out_ack  = out_req;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_path(input logic [6:0] opc);
    case (opc)
      7'b1100011, 7'b1101111: return 0;
      7'b0100011: return 1;
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0000000: return 2;
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    snap_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("path_req", 16'(path_req), 16'(e.preq));
      chk("out_req", 16'(out_req), 16'(e.oreq));
      if (e.oreq) chk("out_sel", 16'(out_sel), 16'(e.osel));
      chk("in_ack", 16'(in_ack), 16'(e.iack));
      if (e.iack) chk("in_err", 16'(in_err), 16'(e.ierr));
      chk("busy", 16'(busy), 16'(e.busy));
      chk("retired", 16'(retired), 16'(e.ret));
    end
  end

  always @(negedge clk) begin
    if (in_req && !prev_req) begin
      lat_cnt  = 0;
      preq_cyc = 0;
      preq_any = 1'b0;
      oreq_any = 1'b0;
    end else begin
      lat_cnt++;
    end
    if (path_req != 3'b000) begin
      preq_cyc++;
      preq_any  = 1'b1;
      last_preq = path_req;
    end
    if (out_req) oreq_any = 1'b1;
    if (out_req && !prev_oreq) sel_log.push_back(out_sel);
    if (in_ack && !prev_ack) begin
      last_lat = lat_cnt;
      last_err = in_err;
    end
    if (in_ack && path_req != 3'b000) overlap = 1'b1;
    prev_req  = in_req;
    prev_ack  = in_ack;
    prev_oreq = out_req;
  end

  task automatic run_txn(input logic [6:0] opc, input logic scramble);
    int    p;
    int    ph[$];
    logic  ok;
    logic [1:0] err;
    snap_t s;
    p = model_path(opc);
    ph.push_back(PhIdle);
    if (p < 0) begin
      ok  = 1'b0;
      err = 2'b01;
    end else if (noise[p]) begin
      ph.push_back(PhDisp);
      repeat (TO) ph.push_back(PhRel);
      ok  = 1'b0;
      err = 2'b10;
    end else if (!echo_en) begin
      repeat (TO) ph.push_back(PhDisp);
      ok  = 1'b0;
      err = 2'b10;
    end else begin
      ph.push_back(PhDisp);
      ph.push_back(PhRel);
      ph.push_back(PhMrg);
      ph.push_back(PhDrn);
      ok  = 1'b1;
      err = 2'b00;
    end
    while (ph.size() <= H) ph.push_back(PhAck);
    while (ph.size() < H + G) ph.push_back(PhIdle);
    for (int j = 0; j < H + G; j++) begin
      s      = '0;
      s.busy = (ph[j] != PhIdle);
      s.ret  = (j > H && ok) ? ret_m + 4'd1 : ret_m;
      if (ph[j] == PhDisp) s.preq = 3'b001 << p;
      if (ph[j] == PhMrg) begin
        s.oreq = 1'b1;
        s.osel = 2'(p);
      end
      if (ph[j] == PhAck) begin
        s.iack = 1'b1;
        s.ierr = err;
      end
      exp_q.push_back(s);
    end
    in_opcode = opc;
    in_req    = 1'b1;
    for (int i = 0; i < H; i++) begin
      @(posedge clk);
      #1;
      if (scramble && i == 1) in_opcode = 7'b1111111;
    end
    in_req = 1'b0;
    repeat (G) begin
      @(posedge clk);
      #1;
    end
    if (ok) ret_m = ret_m + 4'd1;
  endtask

  initial begin
    rst       = 1'b1;
    in_req    = 1'b0;
    in_opcode = 7'b0;
    echo_en   = 1'b1;
    noise     = 3'b000;
    ret_m     = 4'd0;
    overlap   = 1'b0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_oreq = 1'b0;
    lat_cnt   = 0;
    last_lat  = -1;
    preq_cyc  = 0;
    last_preq = 3'b000;
    last_err  = 2'b11;
    preq_any  = 1'b0;
    oreq_any  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ack", 16'(in_ack), 16'd0);
    chk("rst_in_err", 16'(in_err), 16'd0);
    chk("rst_path_req", 16'(path_req), 16'd0);
    chk("rst_out_req", 16'(out_req), 16'd0);
    chk("rst_out_sel", 16'(out_sel), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_retired", 16'(retired), 16'd0);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Store
    run_txn(7'b0100011, 1'b0);
    chk("store_path_req", 16'(last_preq), 16'b010);
    chk("store_latency", 16'(last_lat), 16'd5);
    chk("store_err", 16'(last_err), 16'd0);
    chk("store_retired", 16'(retired), 16'd1);

    // jal, R-type, load (load's opcode changes after sampling)
    run_txn(7'b1101111, 1'b0);
    run_txn(7'b0110011, 1'b0);
    run_txn(7'b0000011, 1'b1);
    chk("sel_count", 16'(sel_log.size()), 16'd4);
    chk("sel0", 16'(sel_log[0]), 16'd1);
    chk("sel1", 16'(sel_log[1]), 16'd0);
    chk("sel2", 16'(sel_log[2]), 16'd2);
    chk("sel3", 16'(sel_log[3]), 16'd2);
    chk("b2b_retired", 16'(retired), 16'd4);

    // U-type is unmapped
    run_txn(7'b0110111, 1'b0);
    chk("illegal_latency", 16'(last_lat), 16'd1);
    chk("illegal_err", 16'(last_err), 16'b01);
    chk("illegal_preq", 16'(preq_any), 16'd0);
    chk("illegal_oreq", 16'(oreq_any), 16'd0);
    chk("illegal_retired", 16'(retired), 16'd4);

    // Branch with silent path: dispatch timeout
    echo_en = 1'b0;
    run_txn(7'b1100011, 1'b0);
    echo_en = 1'b1;
    chk("to_preq_cycles", 16'(preq_cyc), 16'd4);
    chk("to_err", 16'(last_err), 16'b10);
    chk("to_oreq", 16'(oreq_any), 16'd0);
    chk("to_retired", 16'(retired), 16'd4);

    // Branch with stuck path_ack: release timeout
    noise = 3'b001;
    run_txn(7'b1100011, 1'b0);
    noise = 3'b000;
    chk("rel_to_err", 16'(last_err), 16'b10);
    chk("rel_to_preq_cycles", 16'(preq_cyc), 16'd1);

    // Non-selected path_ack bits are ignored
    noise = 3'b011;
    run_txn(7'b0010011, 1'b0);
    noise = 3'b000;
    chk("noise_retired", 16'(retired), 16'd5);
    chk("overlap", 16'(overlap), 16'd0);

    // Reset during MERGE
    in_opcode = 7'b0110011;
    in_req    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_out_req", 16'(out_req), 16'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_req", 16'(out_req), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_path_req", 16'(path_req), 16'd0);
    chk("mid_rst_retired", 16'(retired), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stale_req_ignored", 16'(busy), 16'd0);
    in_req = 1'b0;
    ret_m  = 4'd0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    run_txn(7'b0110011, 1'b0);
    chk("post_rst_retired", 16'(retired), 16'd1);

    // Counter wrap
    repeat (14) run_txn(7'b0000000, 1'b0);
    chk("pre_wrap_retired", 16'(retired), 16'hF);
    run_txn(7'b0110011, 1'b0);
    chk("wrap_retired", 16'(retired), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
